// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display.
// Registered SEG/AN outputs, blanking gap per slot, double-buffered digit writes.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 500000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter int unsigned W         = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [1:0] WR_ADDR,
  input  logic [3:0] WR_DATA,
  input  logic       WR_DP,
  input  logic [3:0] BLANK,
  output logic [7:0] SEG,
  output logic [3:0] AN,
  output logic       FRAME
);

  localparam logic [W-1:0] CntLast     = W'(SCAN_DIV - 1);
  localparam logic [W-1:0] CntBlankEnd = W'(BLANK_CYC - 1);

  typedef enum logic {StBlank, StDrive} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q;
  logic [1:0]     dig_q;
  logic [3:0][4:0] shadow_q, shadow_d;  // {value, dp}
  logic [3:0][4:0] disp_q;
  logic [7:0]     seg_q, seg_d;
  logic [3:0]     an_q, an_d;
  logic           frame_q;
  logic           wrap, commit;

  assign wrap   = (cnt_q == CntLast);
  assign commit = wrap && (dig_q == 2'd3);

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] r;
    unique case (v)
      4'h0: r = 7'b0000001;
      4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;
      4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;
      4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;
      4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0000100;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;
      4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;
      default: r = 7'b0111000;
    endcase
    return r;
  endfunction

  // State register: FSM, slot counter, digit index
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StBlank;
      cnt_q   <= '0;
      dig_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= wrap ? '0 : cnt_q + 1'b1;
      if (wrap) dig_q <= dig_q + 2'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBlank: if (cnt_q == CntBlankEnd) state_d = StDrive;
      StDrive: if (wrap)                 state_d = StBlank;
      default:                           state_d = StBlank;
    endcase
  end

  // Output logic, registered below for one cycle of latency
  always_comb begin
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (state_q == StDrive && !BLANK[dig_q]) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = {hex_decode(disp_q[dig_q][4:1]), ~disp_q[dig_q][0]};
    end
  end

  // A write landing in the commit cycle must be visible in the commit
  always_comb begin
    shadow_d = shadow_q;
    if (WR_EN) shadow_d[WR_ADDR] = {WR_DATA, WR_DP};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_q <= '0;
      disp_q   <= '0;
      an_q     <= 4'hF;
      seg_q    <= 8'hFF;
      frame_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (commit) disp_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= commit;
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign FRAME = frame_q;

endmodule
